mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Memory-side responder for the 8-bit processor: owns the 256x8 unified memory and serves
//  instruction fetches and data loads/stores over req/ack handshakes, with programmable wait
//  states. A preload port writes program images before or between runs. mem_ff mirrors the
//  memory[255] output location.
// PARAMETERS
//  AW           8   address width (memory depth = 2**AW)
//  DW           8   data width
//  WAIT_CYCLES  1   wait-state cycles between request acceptance and ack (0..15)
// PORTS
//  clk       in   1   single clock, rising edge
//  rst       in   1   synchronous, active-high reset
//  if_req    in   1   fetch request, level, held until if_ack
//  if_addr   in   AW  fetch address (pc)
//  if_ack    out  1   one-cycle pulse: fetch done, if_rdata valid
//  if_rdata  out  DW  fetched instruction byte, held until next if_ack
//  d_req     in   1   data request, level, held until d_ack
//  d_we      in   1   1 = store, 0 = load
//  d_addr    in   AW  data address (Rrs)
//  d_wdata   in   DW  store data (Rrd)
//  d_ack     out  1   one-cycle pulse: data access done
//  d_rdata   out  DW  load data, held until next load ack
//  ld_we     in   1   preload write strobe
//  ld_addr   in   AW  preload address
//  ld_data   in   DW  preload data
//  ld_ack    out  1   one-cycle pulse: preload write committed
//  busy      out  1   high in WAIT and RESP
//  mem_ff    out  DW  continuous copy of memory[2**AW-1]
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, wait counter 0, latched request cleared. Array NOT cleared.
//  FSM: IDLE -> WAIT (WAIT_CYCLES>0) or RESP (WAIT_CYCLES=0) on an accepted request;
//       WAIT counts WAIT_CYCLES cycles, then RESP; RESP -> IDLE after one cycle.
//  Accept: in IDLE, at edge N, with priority d_req > if_req > ld_we. Latch port id, we, addr,
//   wdata at accept; later input changes are ignored.
//  Latency: ack is high in cycle N+1+WAIT_CYCLES, i.e. the RESP cycle. The store commits and
//   read data is registered on the edge entering RESP, so rdata is valid with ack.
//  Only one transaction is in flight. The requester deasserts req in the cycle after it sees ack.
//   IDLE samples again one cycle after RESP, so a req still high there starts a new access.
//  Preload: accepted only in IDLE with no d_req or if_req. It commits on the accept edge;
//   ld_ack pulses the next cycle and the FSM stays in IDLE. A ld_we that loses arbitration
//   waits; the loader holds ld_we until ld_ack.
//  Simultaneous d_req and if_req: data is served first. Fetch is accepted in the IDLE cycle
//   after the data RESP if still asserted, so there is no starvation of older instruction data.
//  req dropped after accept: the transaction still completes, the ack pulses, and a store commits.
//  rst mid-operation (WAIT/RESP): transaction aborted, no ack. A store not yet committed is lost.
//  Load after store to same address: returns the new value, because the store committed first.
//  mem_ff updates the cycle after a commit to address 0xFF (store or preload).
//  Addresses are full AW bits, so no wrap or out-of-range case exists.
//  if_rdata changes only on fetch acks; d_rdata changes only on load acks.
// STRUCTURE
//  isa_pkg (shared): AW/DW defaults, opcode constants (ADD=0, SUB=1, LD=2, ST=3, BRZ=4, JAL=5,
//   LUI=2'b10, LLI=2'b11), HALT=8'h70, port-id enum {PORT_D, PORT_IF, PORT_LD}, FSM state enum.
//  Sub-module: mem_array.
//   - 2**AW x DW array with one write port and one synchronous read port.
//   - Separate tap for word 2**AW-1, which drives mem_ff.
//   - Responder FSM, arbiter and wait counter live in mem_responder.
// TESTING
//  1 Preload 0x00=bf; if_req addr 0 (WAIT_CYCLES=1) -> if_ack 2 cycles after accept, if_rdata=bf.
//  2 Store d_addr=0x40 d_wdata=5a, then load 0x40 -> d_ack each access, d_rdata=5a,
//    if_rdata unchanged.
//  3 d_req (load 0x10) and if_req (0x01) raised same cycle -> d_ack first, then if_ack;
//    no cycle with both acks high.
//  4 Store 0x06 to 0xFF -> mem_ff=06 one cycle after d_ack; preload 0xFF=11 -> mem_ff=11.
//  5 rst pulsed in WAIT of store 0x20=aa -> no d_ack, mem[0x20] keeps its old value,
//    outputs 0 the cycle after rst.
//  6 WAIT_CYCLES=0, if_req held high at 0..3 -> one if_ack every 2 cycles, bytes = preload image.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared definitions for the 8-bit processor: widths, opcodes, memory port ids and
// responder FSM states.
package isa_pkg;

   localparam int unsigned AW_DEF = 8;
   localparam int unsigned DW_DEF = 8;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_LD  = 3'd2;
   localparam logic [2:0] OP_ST  = 3'd3;
   localparam logic [2:0] OP_BRZ = 3'd4;
   localparam logic [2:0] OP_JAL = 3'd5;
   localparam logic [1:0] OP_LUI = 2'b10;
   localparam logic [1:0] OP_LLI = 2'b11;
   localparam logic [7:0] HALT   = 8'h70;

   typedef enum logic [1:0] {PORT_D, PORT_IF, PORT_LD} port_e;

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

endpackage

// File: rtl/mem_array.sv
// Unified 2**AW x DW memory: one write port, one registered read port, and a registered
// tap that follows writes to the top word.
module mem_array #(
   parameter int unsigned AW = 8,
   parameter int unsigned DW = 8
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o,
   output logic [DW-1:0] top_word_o
);

   localparam int unsigned Depth = 2 ** AW;

   logic [DW-1:0] mem_q [Depth];
   logic [DW-1:0] rdata_q;
   logic [DW-1:0] top_q;

   // Storage is deliberately not reset; only the top-word tap clears.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         top_q <= '0;
      end else if (we_i && (waddr_i == {AW{1'b1}})) begin
         top_q <= wdata_i;
      end
   end

   assign rdata_o    = rdata_q;
   assign top_word_o = top_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: arbitrates data, fetch and preload requests, inserts wait states
// and answers with one-cycle acks while owning the unified memory.
module mem_responder
   import isa_pkg::*;
#(
   parameter int unsigned AW          = 8,
   parameter int unsigned DW          = 8,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_ack,
   output logic [DW-1:0] if_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_ack,
   output logic [DW-1:0] d_rdata,
   input  logic          ld_we,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_data,
   output logic          ld_ack,
   output logic          busy,
   output logic [DW-1:0] mem_ff
);

   localparam logic [3:0] WaitLast = 4'(WAIT_CYCLES - 1);

   state_e        state_q, state_d;
   port_e         port_q, port_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] if_rdata_q, d_rdata_q;
   logic          ld_ack_q;

   logic          accept, ld_acc, enter_resp;
   logic          arr_we, arr_re;
   logic [AW-1:0] arr_waddr;
   logic [DW-1:0] arr_wdata, arr_rdata;

   // In IDLE the _d fields carry the live request, so a zero-wait access uses it directly.
   always_comb begin
      state_d    = state_q;
      port_d     = port_q;
      cnt_d      = cnt_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      accept     = 1'b0;
      ld_acc     = 1'b0;
      enter_resp = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (d_req) begin
               accept  = 1'b1;
               port_d  = PORT_D;
               we_d    = d_we;
               addr_d  = d_addr;
               wdata_d = d_wdata;
            end else if (if_req) begin
               accept  = 1'b1;
               port_d  = PORT_IF;
               we_d    = 1'b0;
               addr_d  = if_addr;
            end else if (ld_we && !ld_ack_q) begin
               // ld_we is still high during its own ack cycle; don't commit it twice.
               ld_acc = 1'b1;
            end
            if (accept) begin
               cnt_d = '0;
               if (WAIT_CYCLES == 0) begin
                  state_d    = StResp;
                  enter_resp = 1'b1;
               end else begin
                  state_d = StWait;
               end
            end
         end
         StWait: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == WaitLast) begin
               state_d    = StResp;
               enter_resp = 1'b1;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   assign arr_we    = !rst && (ld_acc || (enter_resp && (port_d == PORT_D) && we_d));
   assign arr_re    = enter_resp && !((port_d == PORT_D) && we_d);
   assign arr_waddr = ld_acc ? ld_addr : addr_d;
   assign arr_wdata = ld_acc ? ld_data : wdata_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         port_q     <= PORT_D;
         cnt_q      <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
         ld_ack_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         port_q   <= port_d;
         cnt_q    <= cnt_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         ld_ack_q <= ld_acc;
         if (if_ack) begin
            if_rdata_q <= arr_rdata;
         end
         if (d_ack && !we_q) begin
            d_rdata_q <= arr_rdata;
         end
      end
   end

   mem_array #(
      .AW (AW),
      .DW (DW)
   ) u_mem_array (
      .clk_i      (clk),
      .rst_i      (rst),
      .we_i       (arr_we),
      .waddr_i    (arr_waddr),
      .wdata_i    (arr_wdata),
      .re_i       (arr_re),
      .raddr_i    (addr_d),
      .rdata_o    (arr_rdata),
      .top_word_o (mem_ff)
   );

   // Fresh read data is forwarded during the ack cycle, then held in the _q copies.
   assign if_ack   = (state_q == StResp) && (port_q == PORT_IF);
   assign d_ack    = (state_q == StResp) && (port_q == PORT_D);
   assign if_rdata = if_ack ? arr_rdata : if_rdata_q;
   assign d_rdata  = (d_ack && !we_q) ? arr_rdata : d_rdata_q;
   assign ld_ack   = ld_ack_q;
   assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: random fetch/load/store/preload traffic against a
// byte-array reference, plus a zero-wait instance for back-to-back fetches.
module tb_mem_responder;

   typedef struct packed {
      logic       st;
      logic [7:0] v;
   } dexp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b1;
   logic       if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, ld_we = 1'b0;
   logic [7:0] if_addr = '0, d_addr = '0, d_wdata = '0, ld_addr = '0, ld_data = '0;
   logic       if_ack, d_ack, ld_ack, busy;
   logic [7:0] if_rdata, d_rdata, mem_ff;

   logic       if_req0 = 1'b0, ld_we0 = 1'b0;
   logic [7:0] if_addr0 = '0, ld_addr0 = '0, ld_data0 = '0;
   logic       if_ack0, d_ack0, ld_ack0, busy0;
   logic [7:0] if_rdata0, d_rdata0, mem_ff0;

   mem_responder #(.AW(8), .DW(8), .WAIT_CYCLES(1)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack),
      .busy(busy), .mem_ff(mem_ff)
   );

   mem_responder #(.AW(8), .DW(8), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst),
      .if_req(if_req0), .if_addr(if_addr0), .if_ack(if_ack0), .if_rdata(if_rdata0),
      .d_req(1'b0), .d_we(1'b0), .d_addr(8'h00), .d_wdata(8'h00),
      .d_ack(d_ack0), .d_rdata(d_rdata0),
      .ld_we(ld_we0), .ld_addr(ld_addr0), .ld_data(ld_data0), .ld_ack(ld_ack0),
      .busy(busy0), .mem_ff(mem_ff0)
   );

   int tests_run = 0;
   int tests_failed = 0;

   logic [7:0] mem_m [256];
   logic [7:0] ff_m = '0, if_m = '0, d_m = '0;
   logic [7:0] exp_if [$];
   dexp_t      exp_d [$];
   int         ld_pend = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: pop expected responses whenever the DUT acks.
   always @(negedge clk) begin
      if (if_ack || d_ack) chk("ack_exclusive", 32'(if_ack & d_ack), 0);
      if (if_ack) begin
         if (exp_if.size() == 0) chk("if_unexpected", 32'(if_ack), 0);
         else begin
            if_m = exp_if.pop_front();
            chk("if_rdata", 32'(if_rdata), 32'(if_m));
            chk("d_rdata_hold", 32'(d_rdata), 32'(d_m));
         end
      end
      if (d_ack) begin
         if (exp_d.size() == 0) chk("d_unexpected", 32'(d_ack), 0);
         else begin
            dexp_t e;
            e = exp_d.pop_front();
            if (!e.st) d_m = e.v;
            chk("d_rdata", 32'(d_rdata), 32'(d_m));
            chk("if_rdata_hold", 32'(if_rdata), 32'(if_m));
         end
      end
      if (ld_ack) begin
         if (ld_pend == 0) chk("ld_unexpected", 32'(ld_ack), 0);
         else ld_pend--;
      end
   end

   function automatic logic ack_of(input int sel);
      return (sel == 0) ? if_ack : (sel == 1) ? d_ack : ld_ack;
   endfunction

   // Counts negedges from the current point until the selected ack shows.
   task automatic wait_for(input int sel, input int busy_at, input logic busy_exp,
                           output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == busy_at) chk("busy", 32'(busy), 32'(busy_exp));
      end while (!ack_of(sel) && n < 20);
      if (!ack_of(sel)) chk("ack_timeout", 32'(ack_of(sel)), 1);
   endtask

   task automatic preload(input logic [7:0] a, input logic [7:0] v);
      int n;
      @(posedge clk); #1;
      ld_we = 1'b1; ld_addr = a; ld_data = v;
      mem_m[a] = v;
      if (a == 8'hFF) ff_m = v;
      ld_pend++;
      wait_for(2, 2, 1'b0, n);
      chk("ld_lat", n, 2);
      @(posedge clk); #1;
      ld_we = 1'b0;
      chk("mem_ff", 32'(mem_ff), 32'(ff_m));
   endtask

   task automatic fetch(input logic [7:0] a);
      int n;
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = a;
      exp_if.push_back(mem_m[a]);
      wait_for(0, 2, 1'b1, n);
      chk("if_lat", n, 3);
      @(posedge clk); #1;
      if_req = 1'b0;
   endtask

   task automatic data(input logic we, input logic [7:0] a, input logic [7:0] v,
                       input logic early_drop);
      int n;
      @(posedge clk); #1;
      d_req = 1'b1; d_we = we; d_addr = a; d_wdata = v;
      if (we) begin
         mem_m[a] = v;
         if (a == 8'hFF) ff_m = v;
         exp_d.push_back('{st: 1'b1, v: 8'h00});
      end else begin
         exp_d.push_back('{st: 1'b0, v: mem_m[a]});
      end
      if (early_drop) begin
         @(posedge clk); #1;
         d_req = 1'b0; d_addr = ~a; d_wdata = ~v; d_we = ~we;
         wait_for(1, 1, 1'b1, n);
         chk("d_lat_drop", n, 2);
      end else begin
         wait_for(1, 2, 1'b1, n);
         chk("d_lat", n, 3);
         @(posedge clk); #1;
      end
      d_req = 1'b0;
      chk("mem_ff", 32'(mem_ff), 32'(ff_m));
   endtask

   task automatic both(input logic [7:0] da, input logic [7:0] ia);
      int n;
      @(posedge clk); #1;
      d_req = 1'b1; d_we = 1'b0; d_addr = da;
      if_req = 1'b1; if_addr = ia;
      exp_d.push_back('{st: 1'b0, v: mem_m[da]});
      exp_if.push_back(mem_m[ia]);
      wait_for(1, 0, 1'b0, n);
      chk("both_d_lat", n, 3);
      chk("if_after_d", exp_if.size(), 1);
      @(posedge clk); #1;
      d_req = 1'b0;
      wait_for(0, 0, 1'b0, n);
      chk("both_if_lat", n, 3);
      @(posedge clk); #1;
      if_req = 1'b0;
   endtask

   task automatic reset_in_wait(input logic [7:0] a, input logic [7:0] v);
      @(posedge clk); #1;
      d_req = 1'b1; d_we = 1'b1; d_addr = a; d_wdata = v;
      @(negedge clk);
      @(negedge clk);
      chk("busy_wait", 32'(busy), 1);
      rst = 1'b1; d_req = 1'b0;
      @(negedge clk);
      chk("rst_outputs", {if_ack, d_ack, ld_ack, busy, if_rdata, d_rdata, mem_ff}, 0);
      ff_m = '0; if_m = '0; d_m = '0;
      rst = 1'b0;
   endtask

   initial begin
      logic [7:0] img [4];
      int t, k, prev;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", {if_ack, d_ack, ld_ack, busy, if_rdata, d_rdata, mem_ff}, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      preload(8'h00, 8'hbf);
      for (int i = 1; i < 256; i++) preload(8'(i), 8'($urandom));
      fetch(8'h00);
      data(1'b1, 8'h40, 8'h5a, 1'b0);
      data(1'b0, 8'h40, 8'h00, 1'b0);
      both(8'h10, 8'h01);
      data(1'b1, 8'hFF, 8'h06, 1'b0);
      preload(8'hFF, 8'h11);
      data(1'b1, 8'h33, 8'hc3, 1'b1);
      data(1'b0, 8'h33, 8'h00, 1'b0);
      reset_in_wait(8'h20, ~mem_m[8'h20]);
      data(1'b0, 8'h20, 8'h00, 1'b0);

      for (int i = 0; i < 150; i++) begin
         logic [7:0] a, v;
         a = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
         v = 8'($urandom);
         case ($urandom_range(0, 5))
            0: fetch(a);
            1: data(1'b0, a, v, 1'b0);
            2: data(1'b1, a, v, 1'b0);
            3: preload(a, v);
            4: both(a, 8'($urandom));
            default: data(1'b1, a, v, 1'b1);
         endcase
      end

      // Zero-wait instance: held fetch request streams one byte every two cycles.
      for (int i = 0; i < 4; i++) begin
         img[i] = 8'($urandom);
         @(posedge clk); #1;
         ld_we0 = 1'b1; ld_addr0 = 8'(i); ld_data0 = img[i];
         t = 0;
         do begin @(negedge clk); t++; end while (!ld_ack0 && t < 10);
         chk("ld0_ack", 32'(ld_ack0), 1);
         @(posedge clk); #1;
         ld_we0 = 1'b0;
      end
      @(posedge clk); #1;
      if_req0 = 1'b1; if_addr0 = 8'h00;
      t = 0; k = 0; prev = 0;
      while (k < 4 && t < 40) begin
         @(negedge clk);
         t++;
         if (if_ack0) begin
            chk("if0_rdata", 32'(if_rdata0), 32'(img[k]));
            if (k > 0) chk("if0_spacing", t - prev, 2);
            prev = t;
            k++;
            @(posedge clk); #1;
            if (k == 4) if_req0 = 1'b0;
            else if_addr0 = 8'(k);
         end
      end
      chk("if0_count", k, 4);

      repeat (4) @(negedge clk);
      chk("if_queue_empty", exp_if.size(), 0);
      chk("d_queue_empty", exp_d.size(), 0);
      chk("ld_pending", ld_pend, 0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
